// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver.
// Holds completed words until the consumer pops them; flags words dropped while full.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_BITS:0]    count,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_COUNT = (ADDR_BITS + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_BITS-1:0]  r_wrPtr;
  logic [ADDR_BITS-1:0]  r_rdPtr;
  logic [ADDR_BITS:0]    r_count;
  logic                  r_overflow;

  logic w_wrAccept;
  logic w_rdAccept;
  logic w_drop;

  assign empty = (r_count == '0);
  assign full  = (r_count == DEPTH_COUNT);
  assign count = r_count;
  assign overflow = r_overflow;

  // A simultaneous pop frees the slot, so a write is still taken when full.
  assign w_wrAccept = wr_en & (~full | rd_en);
  assign w_rdAccept = rd_en & ~empty;
  assign w_drop     = wr_en & full & ~rd_en;

  assign rd_data = empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk_100MHz) begin
    if (w_wrAccept) begin
      r_mem[r_wrPtr] <= wr_data;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wrAccept) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_rdAccept) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_wrAccept && !w_rdAccept) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wrAccept && w_rdAccept) begin
        r_count <= r_count - 1'b1;
      end
      // Setting takes priority so a drop in the clearing cycle is not lost.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_fifo;

  localparam int DW = 16;
  localparam int AB = 4;
  localparam int DEPTH = 16;

  logic          clk_100MHz = 1'b0;
  logic          reset = 1'b1;
  logic          wrEn = 1'b0;
  logic [DW-1:0] wrData = '0;
  logic          rdEn = 1'b0;
  logic          clrOverflow = 1'b0;
  logic [DW-1:0] rdData;
  logic          emptyOut;
  logic          fullOut;
  logic [AB:0]   countOut;
  logic          overflowOut;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] modelQ[$];
  bit            modelOvf = 1'b0;

  uart_rx_fifo #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .wr_en       (wrEn),
    .wr_data     (wrData),
    .rd_en       (rdEn),
    .rd_data     (rdData),
    .empty       (emptyOut),
    .full        (fullOut),
    .count       (countOut),
    .overflow    (overflowOut),
    .clr_overflow(clrOverflow)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Model advances on each rising edge from the inputs that were stable across it.
  function automatic void modelStep(bit wr, logic [DW-1:0] d, bit rd, bit clr);
    bit isFull;
    bit isEmpty;
    isFull  = (modelQ.size() == DEPTH);
    isEmpty = (modelQ.size() == 0);
    if (rd && !isEmpty) void'(modelQ.pop_front());
    if (wr && (!isFull || rd)) modelQ.push_back(d);
    if (wr && isFull && !rd) modelOvf = 1'b1;
    else if (clr) modelOvf = 1'b0;
  endfunction

  always @(negedge clk_100MHz) begin
    checkOutput("rd_data", 32'(rdData), (modelQ.size() != 0) ? 32'(modelQ[0]) : 32'd0);
    checkOutput("count", 32'(countOut), 32'(modelQ.size()));
    checkOutput("empty", 32'(emptyOut), 32'(modelQ.size() == 0));
    checkOutput("full", 32'(fullOut), 32'(modelQ.size() == DEPTH));
    checkOutput("overflow", 32'(overflowOut), 32'(modelOvf));
  end

  task automatic applyStimulus(bit wr, logic [DW-1:0] d, bit rd, bit clr);
    wrEn = wr;
    wrData = d;
    rdEn = rd;
    clrOverflow = clr;
    @(posedge clk_100MHz);
    if (!reset) modelStep(wr, d, rd, clr);
    #1;
    wrEn = 1'b0;
    rdEn = 1'b0;
    clrOverflow = 1'b0;
  endtask

  task automatic checkIdleReset(string tag);
    checkOutput({tag, "_empty"}, 32'(emptyOut), 32'd1);
    checkOutput({tag, "_full"}, 32'(fullOut), 32'd0);
    checkOutput({tag, "_count"}, 32'(countOut), 32'd0);
    checkOutput({tag, "_rd_data"}, 32'(rdData), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflowOut), 32'd0);
  endtask

  task automatic pulseReset();
    #2;
    reset = 1'b1;
    modelQ.delete();
    modelOvf = 1'b0;
    #1;
    checkIdleReset("async_reset");
    @(posedge clk_100MHz);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rv;
    repeat (2) @(posedge clk_100MHz);
    #1;
    checkIdleReset("reset");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(16'h0300 + i), 1'b0, 1'b0);
    checkOutput("pre_reset_count", 32'(countOut), 32'd5);
    pulseReset();

    applyStimulus(1'b1, 16'hA5A5, 1'b0, 1'b0);
    checkOutput("first_word", 32'(rdData), 32'hA5A5);
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
    checkOutput("two_words_count", 32'(countOut), 32'd2);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("second_word", 32'(rdData), 32'h1234);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("drained_empty", 32'(emptyOut), 32'd1);
    checkOutput("drained_rd_data", 32'(rdData), 32'd0);

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
    checkOutput("fill_full", 32'(fullOut), 32'd1);
    checkOutput("fill_count", 32'(countOut), 32'd16);
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
    checkOutput("drop_overflow", 32'(overflowOut), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("ordered_pop", 32'(rdData), 32'(i));
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end
    checkOutput("dead_absent", 32'(rdData), 32'd0);

    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("ovf_cleared", 32'(overflowOut), 32'd0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
    checkOutput("full_rw_count", 32'(countOut), 32'd16);
    checkOutput("full_rw_ovf", 32'(overflowOut), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) checkOutput("beef_16th", 32'(rdData), 32'hBEEF);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end

    applyStimulus(1'b1, 16'h0042, 1'b1, 1'b0);
    checkOutput("empty_rw_count", 32'(countOut), 32'd1);
    checkOutput("empty_rw_data", 32'(rdData), 32'h0042);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("empty_pop_count", 32'(countOut), 32'd0);

    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, DW'(16'h2000 + k), 1'b0, 1'b0);
      checkOutput("wrap_data", 32'(rdData), 32'(16'h2000 + k));
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h8888, 1'b0, 1'b1);
    checkOutput("clr_vs_drop", 32'(overflowOut), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("clr_alone", 32'(overflowOut), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      rv = DW'($urandom);
      applyStimulus(($urandom_range(0, 99) < 55), rv, ($urandom_range(0, 99) < 45),
                    ($urandom_range(0, 99) < 10));
      if ($urandom_range(0, 999) == 0) pulseReset();
    end

    @(negedge clk_100MHz);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
